spi_axil_master: RTL and testbench
==================================

Name: spi_axil_master

Overview:
- SPI slave front end that turns SPI frames from an external host into single AXI-Lite master transactions.
- Its m_axil_* outputs drive the s_axil_* slave port of the indirect-access register controller directly downstream.
- SPI pins are oversampled in the AXI-Lite clock domain, so there is no second clock.
- Exactly one outstanding AXI-Lite transaction at any time.

Parameters:
SYNC_STAGES, 2, synchronizer depth on spi_sclk, spi_csn and spi_mosi (minimum 2)
ADDR_W, 12, AXI-Lite address width
RESP_ERR_MASK, 2'b10, a response with this bit set counts as an error

Ports:
axil_aclk  in  1  single clock
axil_aresetn  in  1  reset, asynchronous assert, active-low
spi_sclk  in  1  SPI clock, mode 0, frequency at most axil_aclk/8
spi_csn  in  1  SPI chip select, active-low
spi_mosi  in  1  SPI data in
spi_miso  out  1  SPI data out
m_axil_awaddr  out  ADDR_W  write address
m_axil_awprot  out  3  constant 3'b000
m_axil_awvalid / m_axil_awready  out / in  1  AW handshake
m_axil_wdata  out  32  write data
m_axil_wstrb  out  4  constant 4'hF
m_axil_wvalid / m_axil_wready  out / in  1  W handshake
m_axil_bresp  in  2  write response
m_axil_bvalid / m_axil_bready  in / out  1  B handshake
m_axil_araddr  out  ADDR_W  read address
m_axil_arprot  out  3  constant 3'b000
m_axil_arvalid / m_axil_arready  out / in  1  AR handshake
m_axil_rdata  in  32  read data
m_axil_rresp  in  2  read response
m_axil_rvalid / m_axil_rready  in / out  1  R handshake
busy  out  1  AXI-Lite transaction in flight
err_sticky  out  1  an error response was received, or read data was late
err_clr  in  1  single-cycle pulse that clears err_sticky

Behaviour:
- Reset values: every valid/ready output 0, spi_miso 0, busy 0, err_sticky 0, all address/data outputs 0.
- Synchronization: spi_sclk, spi_csn and spi_mosi pass through SYNC_STAGES flops. A rising or falling sclk edge is detected one cycle after the last sync stage.
- SPI mode 0: MOSI sampled on the rising edge; MISO updated on the falling edge. All frames are MSB first.
- Frame layout: CMD[7:0], then ADDR[15:0], then DATA.
  - Write frame (CMD 0x00): 32 data bits in, 56 bits total.
  - Read frame (CMD 0x80): 8 turnaround bits, then 32 data bits out, 64 bits total.
  - Any other CMD: frame is consumed, no AXI transaction, MISO stays 0.
  - ADDR[15:ADDR_W] is ignored.
- Bit counter: 7 bits, cleared while spi_csn is high.
- Frame FSM states: IDLE, CMD, ADDR, TURN, WDATA, RDATA, DONE. IDLE moves to CMD on csn fall.
- Write launch: on the cycle after the 56th rising edge, awvalid and wvalid assert together.
  - Each is held until its own handshake completes; AW and W may complete in either order.
  - bready asserts once both have completed and stays high until bvalid.
- Read launch: on the cycle after the 24th rising edge, arvalid asserts and is held until arready.
  - rready then asserts until rvalid; rdata is captured on the R handshake.
- AXI FSM states: A_IDLE, A_WR, A_B, A_AR, A_R. busy = (state != A_IDLE).
- MISO:
  - Drives 0 outside the read data phase.
  - On the falling edge that ends turnaround bit 8, MISO loads captured rdata[31]. Each following falling edge shifts out the next lower bit.
  - If the R handshake has not completed by that falling edge, shift out 32'hFFFF_FFFF and set err_sticky.
- Errors: bresp or rresp with RESP_ERR_MASK set sets err_sticky.
  - err_clr clears it.
  - If a set condition and err_clr occur in the same cycle, set wins.
- csn rises mid-frame:
  - Shifting aborts and the frame FSM returns to IDLE.
  - A write is never issued for an incomplete frame.
  - An AXI transaction already launched runs to completion; valids are never dropped before handshake.
- New frame while busy: a launch point reached while busy=1 is dropped and sets err_sticky.
- Reset asserted mid-transaction: all outputs return immediately to reset values.

Decomposition:
- Shared package spi_axil_pkg holds:
  - CMD_WR = 8'h00 and CMD_RD = 8'h80
  - frame bit counts: 8, 24, 32, 56, 64
  - frame-state and AXI-state encodings (one-hot)
- Sub-module spi_sync_edge: parameterised synchronizer on the three inputs, producing synced csn, synced mosi, and sclk_rise/sclk_fall pulses.

Test Plan:
- Write: CMD 0x00, ADDR 0x0008, DATA 0x8000_0123 with immediate ready -> AW addr 0x008, W data 0x80000123, wstrb F, single B handshake, busy low afterwards, err_sticky 0.
- Read: CMD 0x80, ADDR 0x0004, slave returns 0xA5A5_5A5A with rresp OKAY after 3 cycles -> araddr 0x004, MISO shifts out A5A55A5A MSB first during bits 33-64.
- Backpressure: awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles, bready rises only after both handshakes complete.
- Abort: csn deasserted after 40 bits of a write frame -> no AWVALID/WVALID; next full frame executes normally.
- Late read and errors: rvalid delayed past turnaround -> MISO reads 0xFFFFFFFF and err_sticky=1. Separately, bresp=2'b10 -> err_sticky=1, and err_clr clears it.
- Reset mid-read with arvalid high -> arvalid, rready and spi_miso go to 0 asynchronously, and the FSM restarts cleanly on the next frame.

Source files
------------

// File: rtl/spi_axil_pkg.sv
// Shared constants and state encodings for the SPI to AXI-Lite bridge.
package spi_axil_pkg;

  localparam logic [7:0] CMD_WR = 8'h00;
  localparam logic [7:0] CMD_RD = 8'h80;

  // Rising-edge counts at which each frame phase ends
  localparam logic [6:0] BITS_CMD      = 7'd8;
  localparam logic [6:0] BITS_ADDR     = 7'd24;
  localparam logic [6:0] BITS_TURN     = 7'd32;
  localparam logic [6:0] BITS_WR_FRAME = 7'd56;
  localparam logic [6:0] BITS_RD_FRAME = 7'd64;

  typedef enum logic [6:0] {
    IDLE  = 7'b0000001,
    CMD   = 7'b0000010,
    ADDR  = 7'b0000100,
    TURN  = 7'b0001000,
    WDATA = 7'b0010000,
    RDATA = 7'b0100000,
    DONE  = 7'b1000000
  } frame_state_e;

  typedef enum logic [4:0] {
    A_IDLE = 5'b00001,
    A_WR   = 5'b00010,
    A_B    = 5'b00100,
    A_AR   = 5'b01000,
    A_R    = 5'b10000
  } axi_state_e;

endpackage

// File: rtl/spi_axil_master_if.sv
// AXI-Lite bus between the SPI bridge (master) and the downstream register slave.
interface spi_axil_master_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizes the SPI pins into the AXI clock domain and flags sclk edges.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic csn_i,
  input  logic mosi_i,
  output logic csn_o,
  output logic mosi_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o
);
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] csn_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_last_q;

  // Synchronizer chains plus one extra sclk flop for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q      <= '0;
      csn_q       <= '1;
      mosi_q      <= '0;
      sclk_last_q <= 1'b0;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      csn_q       <= {csn_q[SYNC_STAGES-2:0], csn_i};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sclk_last_q <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign csn_o       = csn_q[SYNC_STAGES-1];
  assign mosi_o      = mosi_q[SYNC_STAGES-1];
  assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_last_q;
  assign sclk_fall_o = ~sclk_q[SYNC_STAGES-1] & sclk_last_q;
endmodule

// File: rtl/spi_axil_master.sv
// SPI mode-0 slave that turns each host frame into one AXI-Lite transaction.
module spi_axil_master
  import spi_axil_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ADDR_W        = 12,
  parameter logic [1:0]  RESP_ERR_MASK = 2'b10
) (
  input  logic               axil_aclk,
  input  logic               axil_aresetn,
  input  logic               spi_sclk,
  input  logic               spi_csn,
  input  logic               spi_mosi,
  output logic               spi_miso,
  spi_axil_master_if.master  m_axil,
  output logic               busy,
  output logic               err_sticky,
  input  logic               err_clr
);
  logic csn_s, mosi_s, sclk_rise, sclk_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (axil_aclk),
    .rst_ni      (axil_aresetn),
    .sclk_i      (spi_sclk),
    .csn_i       (spi_csn),
    .mosi_i      (spi_mosi),
    .csn_o       (csn_s),
    .mosi_o      (mosi_s),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall)
  );

  frame_state_e      fstate_q, fstate_d;
  logic [6:0]        cnt_q, cnt_d, cnt_next;
  logic [30:0]       sr_q, sr_d;
  logic [31:0]       frame_word;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              launch_wr, launch_rd;

  axi_state_e        astate_q, astate_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d, msr_q, msr_d;
  logic              rdv_q, rdv_d, miso_q, miso_d, err_q, err_d, err_set;

  // Word as it stands including the bit sampled this cycle
  assign frame_word = {sr_q, mosi_s};
  assign cnt_next   = cnt_q + 7'd1;

  // State registers
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      fstate_q  <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      astate_q  <= A_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      msr_q     <= '0;
      rdv_q     <= 1'b0;
      miso_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      fstate_q  <= fstate_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      astate_q  <= astate_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      msr_q     <= msr_d;
      rdv_q     <= rdv_d;
      miso_q    <= miso_d;
      err_q     <= err_d;
    end
  end

  // Frame FSM: shift MOSI on rising edges and raise launch pulses at phase ends
  always_comb begin
    fstate_d  = fstate_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    launch_wr = 1'b0;
    launch_rd = 1'b0;
    if (csn_s) begin
      fstate_d = IDLE;
      cnt_d    = '0;
    end else if (fstate_q == IDLE) begin
      fstate_d = CMD;
    end else if (sclk_rise) begin
      cnt_d = cnt_next;
      sr_d  = frame_word[30:0];
      case (fstate_q)
        CMD: if (cnt_next == BITS_CMD) begin
          cmd_d    = frame_word[7:0];
          fstate_d = ADDR;
        end
        ADDR: if (cnt_next == BITS_ADDR) begin
          addr_d = frame_word[ADDR_W-1:0];
          if (cmd_q == CMD_RD) begin
            fstate_d  = TURN;
            launch_rd = 1'b1;
          end else if (cmd_q == CMD_WR) begin
            fstate_d = WDATA;
          end else begin
            fstate_d = DONE;
          end
        end
        TURN:  if (cnt_next == BITS_TURN) fstate_d = RDATA;
        WDATA: if (cnt_next == BITS_WR_FRAME) begin
          launch_wr = 1'b1;
          fstate_d  = DONE;
        end
        RDATA: if (cnt_next == BITS_RD_FRAME) fstate_d = DONE;
        default: ;
      endcase
    end
  end

  // AXI FSM, MISO shifter and sticky error
  always_comb begin
    astate_d  = astate_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rdv_d     = rdv_q;
    msr_d     = msr_q;
    miso_d    = miso_q;
    err_set   = 1'b0;

    if ((launch_wr || launch_rd) && (astate_q != A_IDLE)) err_set = 1'b1;

    case (astate_q)
      A_IDLE: begin
        if (launch_wr) begin
          astate_d  = A_WR;
          awaddr_d  = addr_q;
          wdata_d   = frame_word;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (launch_rd) begin
          astate_d = A_AR;
          araddr_d = frame_word[ADDR_W-1:0];
        end
      end
      A_WR: begin
        aw_done_d = aw_done_q | m_axil.awready;
        w_done_d  = w_done_q | m_axil.wready;
        if (aw_done_d && w_done_d) astate_d = A_B;
      end
      A_B: if (m_axil.bvalid) begin
        astate_d = A_IDLE;
        if ((m_axil.bresp & RESP_ERR_MASK) != 2'b00) err_set = 1'b1;
      end
      A_AR: if (m_axil.arready) astate_d = A_R;
      A_R: if (m_axil.rvalid) begin
        astate_d = A_IDLE;
        rdata_d  = m_axil.rdata;
        rdv_d    = 1'b1;
        if ((m_axil.rresp & RESP_ERR_MASK) != 2'b00) err_set = 1'b1;
      end
      default: astate_d = A_IDLE;
    endcase

    // Data from an earlier read must never be shifted out for a new read frame
    if (launch_rd) rdv_d = 1'b0;

    if (csn_s) begin
      miso_d = 1'b0;
    end else if (sclk_fall) begin
      if (fstate_q == RDATA && cnt_q == BITS_TURN) begin
        if (rdv_q) begin
          miso_d = rdata_q[31];
          msr_d  = {rdata_q[30:0], 1'b0};
        end else begin
          miso_d  = 1'b1;
          msr_d   = '1;
          err_set = 1'b1;
        end
      end else if (fstate_q == RDATA) begin
        miso_d = msr_q[31];
        msr_d  = {msr_q[30:0], 1'b0};
      end else begin
        miso_d = 1'b0;
      end
    end

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  assign m_axil.awaddr  = awaddr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = (astate_q == A_WR) && !aw_done_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = 4'hF;
  assign m_axil.wvalid  = (astate_q == A_WR) && !w_done_q;
  assign m_axil.bready  = (astate_q == A_B);
  assign m_axil.araddr  = araddr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = (astate_q == A_AR);
  assign m_axil.rready  = (astate_q == A_R);
  assign spi_miso       = miso_q;
  assign busy           = (astate_q != A_IDLE);
  assign err_sticky     = err_q;
endmodule

// File: tb/tb_spi_axil_master.sv
// Scoreboard bench: SPI host model, AXI-Lite slave model with programmable delays.
module tb_spi_axil_master;
  logic clk = 1'b0;
  logic rst_n, sclk, csn, mosi, miso, busy, err, err_clr;

  always #5 clk = ~clk;

  spi_axil_master_if #(.ADDR_W(12)) axil ();

  spi_axil_master #(.SYNC_STAGES(2), .ADDR_W(12), .RESP_ERR_MASK(2'b10)) dut (
    .axil_aclk    (clk),
    .axil_aresetn (rst_n),
    .spi_sclk     (sclk),
    .spi_csn      (csn),
    .spi_mosi     (mosi),
    .spi_miso     (miso),
    .m_axil       (axil),
    .busy         (busy),
    .err_sticky   (err),
    .err_clr      (err_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard queues
  logic [11:0] exp_aw_q[$];
  logic [31:0] exp_w_q[$];
  logic [11:0] exp_ar_q[$];
  logic [31:0] exp_miso_q[$];

  // Slave configuration
  int unsigned aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  // Slave bookkeeping shared with the monitor
  int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_got, w_got, ar_got, b_fire, r_fire;
  int unsigned aw_cycles = 0, w_cycles = 0, bready_early = 0;
  int unsigned aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;

  // AXI-Lite slave: drives responses on the falling clock edge
  initial begin
    axil.awready = 0; axil.wready = 0; axil.bvalid = 0; axil.bresp = 0;
    axil.arready = 0; axil.rvalid = 0; axil.rresp = 0; axil.rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axil.awready = 0; axil.wready = 0; axil.bvalid = 0;
        axil.arready = 0; axil.rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
      end else begin
        if (axil.awvalid && !axil.awready) begin
          if (aw_cnt >= aw_delay) axil.awready = 1; else aw_cnt++;
        end else if (!axil.awvalid) begin
          axil.awready = 0; aw_cnt = 0;
        end
        if (axil.wvalid && !axil.wready) begin
          if (w_cnt >= w_delay) axil.wready = 1; else w_cnt++;
        end else if (!axil.wvalid) begin
          axil.wready = 0; w_cnt = 0;
        end
        if (axil.arvalid && !axil.arready) begin
          if (ar_cnt >= ar_delay) axil.arready = 1; else ar_cnt++;
        end else if (!axil.arvalid) begin
          axil.arready = 0; ar_cnt = 0;
        end
        if (axil.bvalid) begin
          if (b_fire) begin axil.bvalid = 0; b_fire = 0; end
        end else if (aw_got && w_got) begin
          if (b_cnt >= b_delay) begin
            axil.bvalid = 1; axil.bresp = bresp_cfg;
            aw_got = 0; w_got = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (axil.rvalid) begin
          if (r_fire) begin axil.rvalid = 0; r_fire = 0; end
        end else if (ar_got) begin
          if (r_cnt >= r_delay) begin
            axil.rvalid = 1; axil.rdata = rdata_cfg; axil.rresp = rresp_cfg;
            ar_got = 0; r_cnt = 0;
          end else r_cnt++;
        end
      end
    end
  end

  // Monitor: samples just before the rising edge, compares handshakes with the scoreboard
  initial begin
    forever begin
      @(negedge clk); #3;
      if (rst_n) begin
        if (axil.awvalid) aw_cycles++;
        if (axil.wvalid) w_cycles++;
        if (axil.bready && (axil.awvalid || axil.wvalid)) bready_early++;
        if (axil.awvalid && axil.awready) begin
          aw_got = 1; aw_hs++;
          check_eq("aw_expected", exp_aw_q.size() != 0, 1);
          if (exp_aw_q.size() != 0) check_eq("awaddr", axil.awaddr, exp_aw_q.pop_front());
          check_eq("awprot", axil.awprot, 3'b000);
        end
        if (axil.wvalid && axil.wready) begin
          w_got = 1; w_hs++;
          check_eq("w_expected", exp_w_q.size() != 0, 1);
          if (exp_w_q.size() != 0) check_eq("wdata", axil.wdata, exp_w_q.pop_front());
          check_eq("wstrb", axil.wstrb, 4'hF);
        end
        if (axil.bvalid && axil.bready) begin b_fire = 1; b_hs++; end
        if (axil.arvalid && axil.arready) begin
          ar_got = 1; ar_hs++;
          check_eq("ar_expected", exp_ar_q.size() != 0, 1);
          if (exp_ar_q.size() != 0) check_eq("araddr", axil.araddr, exp_ar_q.pop_front());
          check_eq("arprot", axil.arprot, 3'b000);
        end
        if (axil.rvalid && axil.rready) r_fire = 1;
      end
    end
  end

  // SPI host, mode 0, sclk = aclk/8; captures MISO bits 33..64
  task automatic spi_xfer(input logic [63:0] frame, input int unsigned nbits, output logic [31:0] rx);
    rx = '0;
    @(negedge clk);
    csn = 0; #40;
    for (int unsigned i = 0; i < nbits; i++) begin
      mosi = frame[63-i]; #40;
      if (i >= 32) rx = {rx[30:0], miso};
      sclk = 1; #40;
      sclk = 0;
    end
    #40; csn = 1; mosi = 0; #80;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data);
    logic [31:0] rx;
    exp_aw_q.push_back(addr[11:0]);
    exp_w_q.push_back(data);
    spi_xfer({8'h00, addr, data, 8'h00}, 56, rx);
  endtask

  task automatic do_read(input string tag, input logic [15:0] addr, input logic [31:0] rd,
                         input logic [31:0] exp_word);
    logic [31:0] rx;
    exp_ar_q.push_back(addr[11:0]);
    exp_miso_q.push_back(exp_word);
    rdata_cfg = rd;
    spi_xfer({8'h80, addr, 40'h0}, 64, rx);
    check_eq(tag, rx, exp_miso_q.pop_front());
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check_eq(tag, busy, 0);
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rx;
    int unsigned snap_aw, snap_w, snap_b;
    rst_n = 0; sclk = 0; csn = 1; mosi = 0; err_clr = 0;
    repeat (4) @(negedge clk);
    check_eq("rst_awvalid", axil.awvalid, 0);
    check_eq("rst_wvalid", axil.wvalid, 0);
    check_eq("rst_bready", axil.bready, 0);
    check_eq("rst_arvalid", axil.arvalid, 0);
    check_eq("rst_rready", axil.rready, 0);
    check_eq("rst_miso", miso, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_addr_data", {axil.awaddr, axil.araddr, axil.wdata[7:0]}, 32'h0);
    rst_n = 1;
    repeat (4) @(negedge clk);

    // Plain write
    do_write(16'h0008, 32'h8000_0123);
    wait_idle("wr1_idle");
    check_eq("wr1_bhs", b_hs, 1);
    check_eq("wr1_err", err, 0);

    // Plain read, data returned after 3 cycles
    r_delay = 3;
    do_read("rd1_miso", 16'h0004, 32'hA5A5_5A5A, 32'hA5A5_5A5A);
    wait_idle("rd1_idle");
    check_eq("rd1_err", err, 0);

    // AW backpressure
    aw_delay = 4; aw_cycles = 0; w_cycles = 0; bready_early = 0;
    do_write(16'h0010, 32'h1234_5678);
    wait_idle("bp_idle");
    check_eq("bp_aw_cycles", aw_cycles, 5);
    check_eq("bp_w_cycles", w_cycles, 1);
    check_eq("bp_bready_early", bready_early, 0);
    aw_delay = 0;

    // Abort after 40 bits, then a full frame with ignored upper address bits
    snap_aw = aw_cycles; snap_w = w_cycles;
    spi_xfer({8'h00, 16'h0020, 32'hCAFE_F00D, 8'h00}, 40, rx);
    repeat (20) @(negedge clk);
    check_eq("abort_aw", aw_cycles - snap_aw, 0);
    check_eq("abort_w", w_cycles - snap_w, 0);
    check_eq("abort_busy", busy, 0);
    do_write(16'hFABC, 32'hDEAD_BEEF);
    wait_idle("post_abort_idle");

    // Late read data
    r_delay = 100;
    do_read("late_miso", 16'h0100, 32'h1111_2222, 32'hFFFF_FFFF);
    check_eq("late_err", err, 1);
    wait_idle("late_idle");
    pulse_clr();
    check_eq("late_clr", err, 0);
    r_delay = 0;

    // Error responses: masked bit sets, unmasked bit does not
    bresp_cfg = 2'b01;
    do_write(16'h0030, 32'h0000_0001);
    wait_idle("bresp01_idle");
    check_eq("bresp01_err", err, 0);
    bresp_cfg = 2'b10;
    do_write(16'h0034, 32'h0000_0002);
    wait_idle("bresp10_idle");
    check_eq("bresp10_err", err, 1);
    pulse_clr();
    check_eq("bresp_clr", err, 0);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b11;
    do_read("rresp_miso", 16'h0040, 32'h0F0F_00FF, 32'h0F0F_00FF);
    wait_idle("rresp_idle");
    check_eq("rresp_err", err, 1);
    pulse_clr();
    rresp_cfg = 2'b00;

    // Unknown command: no transaction, MISO stays low
    snap_aw = aw_hs; snap_w = ar_hs;
    spi_xfer({8'h42, 16'h0004, 40'h0}, 64, rx);
    check_eq("unk_miso", rx, 0);
    check_eq("unk_aw", aw_hs - snap_aw, 0);
    check_eq("unk_ar", ar_hs - snap_w, 0);
    check_eq("unk_err", err, 0);

    // Launch while busy is dropped and flagged
    b_delay = 1000; snap_aw = aw_hs; snap_b = b_hs;
    do_write(16'h0050, 32'h5555_AAAA);
    spi_xfer({8'h00, 16'h0054, 32'h6666_BBBB, 8'h00}, 56, rx);
    check_eq("drop_err", err, 1);
    wait_idle("drop_idle");
    check_eq("drop_aw", aw_hs - snap_aw, 1);
    check_eq("drop_b", b_hs - snap_b, 1);
    b_delay = 0;
    pulse_clr();
    check_eq("drop_clr", err, 0);

    // Reset while arvalid is held
    ar_delay = 10000;
    exp_ar_q.push_back(12'h200);
    spi_xfer({8'h80, 16'h0200, 40'h0}, 30, rx);
    @(negedge clk);
    check_eq("pre_rst_arvalid", axil.arvalid, 1);
    rst_n = 0; #1;
    check_eq("midrst_arvalid", axil.arvalid, 0);
    check_eq("midrst_rready", axil.rready, 0);
    check_eq("midrst_miso", miso, 0);
    check_eq("midrst_busy", busy, 0);
    exp_ar_q.delete();
    ar_delay = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    do_read("post_rst_miso", 16'h0FFC, 32'h0F1E_2D3C, 32'h0F1E_2D3C);
    wait_idle("post_rst_idle");
    check_eq("post_rst_err", err, 0);

    check_eq("aw_q_drained", exp_aw_q.size(), 0);
    check_eq("w_q_drained", exp_w_q.size(), 0);
    check_eq("ar_q_drained", exp_ar_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
